// File: rtl/imul_shared_arbiter_pkg.sv
// Shared types and message widths for the multiplier-sharing arbiter.
package imul_arb_pkg;

   localparam int IMUL_REQ_NBITS  = 64;
   localparam int IMUL_RESP_NBITS = 32;

   typedef enum logic [1:0] {
      IMUL_ARB_IDLE = 2'd0,
      IMUL_ARB_HOLD = 2'd1,
      IMUL_ARB_BUSY = 2'd2
   } imul_arb_state_t;

endpackage

// File: rtl/imul_shared_arbiter_if.sv
// Bundles the core-side and multiplier-side val/rdy channels of the arbiter.
interface imul_shared_arbiter_if #(
   parameter int nreqs = 4
);
   import imul_arb_pkg::*;

   logic [nreqs-1:0]                 req_val;
   logic [nreqs-1:0]                 req_rdy;
   logic [nreqs*IMUL_REQ_NBITS-1:0]  req_msg;
   logic [nreqs-1:0]                 resp_val;
   logic [nreqs-1:0]                 resp_rdy;
   logic [nreqs*IMUL_RESP_NBITS-1:0] resp_msg;

   logic                             mul_req_val;
   logic                             mul_req_rdy;
   logic [IMUL_REQ_NBITS-1:0]        mul_req_msg;
   logic                             mul_resp_val;
   logic                             mul_resp_rdy;
   logic [IMUL_RESP_NBITS-1:0]       mul_resp_msg;

   // Arbiter view
   modport master (
      input  req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
      output req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
   );

   // Environment view: requesters plus the multiplier
   modport slave (
      output req_val, req_msg, resp_rdy, mul_req_rdy, mul_resp_val, mul_resp_msg,
      input  req_rdy, resp_val, resp_msg, mul_req_val, mul_req_msg, mul_resp_rdy
   );

endinterface

// File: rtl/imul_shared_arbiter_picker.sv
// Combinational round-robin picker: first valid index searching circularly from ptr.
module imul_rr_picker #(
   parameter  int nreqs     = 4,
   localparam int idx_nbits = $clog2(nreqs)
) (
   input  logic [nreqs-1:0]     val,
   input  logic [idx_nbits-1:0] ptr,
   output logic [idx_nbits-1:0] pick,
   output logic                 any
);

   logic [idx_nbits-1:0] cand [nreqs];
   logic [nreqs-1:0]     cand_val;

   // Candidate gi is ptr+gi with an explicit wrap, so non-power-of-2 counts never alias.
   for (genvar gi = 0; gi < nreqs; gi++) begin : g_cand
      logic [idx_nbits:0] sum;
      assign sum           = {1'b0, ptr} + (idx_nbits+1)'(gi);
      assign cand[gi]      = (sum >= (idx_nbits+1)'(nreqs))
                             ? idx_nbits'(sum - (idx_nbits+1)'(nreqs))
                             : sum[idx_nbits-1:0];
      assign cand_val[gi]  = val[cand[gi]];
   end

   always_comb begin
      logic found;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < nreqs; i++) begin
         if (!found && cand_val[i]) begin
            pick  = cand[i];
            found = 1'b1;
         end
      end
   end

   assign any = |val;

endmodule

// File: rtl/imul_shared_arbiter.sv
// Round-robin sharing of one iterative multiplier among nreqs requesters,
// one transaction in flight, response steered back to the granted lane.
module imul_shared_arbiter
   import imul_arb_pkg::*;
#(
   parameter  int nreqs     = 4,
   localparam int idx_nbits = $clog2(nreqs)
) (
   input logic                   clk,
   input logic                   reset,
   imul_shared_arbiter_if.master bus
);

   imul_arb_state_t      state_reg, state_next;
   logic [idx_nbits-1:0] ptr_reg, ptr_next;
   logic [idx_nbits-1:0] owner_reg, owner_next;
   logic [idx_nbits-1:0] pick, sel;
   logic                 any_val;

   logic [nreqs-1:0]          req_rdy_c, resp_val_c;
   logic                      mul_req_val_c, mul_resp_rdy_c;
   logic [IMUL_REQ_NBITS-1:0] req_msg_lane [nreqs];

   for (genvar gi = 0; gi < nreqs; gi++) begin : g_lane
      assign req_msg_lane[gi] = bus.req_msg[gi*IMUL_REQ_NBITS +: IMUL_REQ_NBITS];
   end

   imul_rr_picker #(.nreqs(nreqs)) u_picker (
      .val  (bus.req_val),
      .ptr  (ptr_reg),
      .pick (pick),
      .any  (any_val)
   );

   // Only IDLE follows the live pick; HOLD and BUSY are locked to owner.
   assign sel = (state_reg == IMUL_ARB_IDLE) ? pick : owner_reg;

   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      owner_next     = owner_reg;
      req_rdy_c      = '0;
      resp_val_c     = '0;
      mul_req_val_c  = 1'b0;
      mul_resp_rdy_c = 1'b0;
      case (state_reg)
         IMUL_ARB_IDLE: begin
            mul_req_val_c = any_val;
            if (any_val) begin
               req_rdy_c[pick] = bus.mul_req_rdy;
               owner_next      = pick;
               state_next      = bus.mul_req_rdy ? IMUL_ARB_BUSY : IMUL_ARB_HOLD;
            end
         end
         IMUL_ARB_HOLD: begin
            mul_req_val_c        = bus.req_val[owner_reg];
            req_rdy_c[owner_reg] = bus.mul_req_rdy;
            if (bus.req_val[owner_reg] && bus.mul_req_rdy) begin
               state_next = IMUL_ARB_BUSY;
            end
         end
         IMUL_ARB_BUSY: begin
            resp_val_c[owner_reg] = bus.mul_resp_val;
            mul_resp_rdy_c        = bus.resp_rdy[owner_reg];
            if (bus.mul_resp_val && bus.resp_rdy[owner_reg]) begin
               // Just-served requester drops to lowest priority.
               ptr_next   = (owner_reg == idx_nbits'(nreqs - 1)) ? '0 : owner_reg + 1'b1;
               state_next = IMUL_ARB_IDLE;
            end
         end
         default: state_next = IMUL_ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IMUL_ARB_IDLE;
         ptr_reg   <= '0;
         owner_reg <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         owner_reg <= owner_next;
      end
   end

   // All outputs are held low for the whole reset pulse.
   assign bus.req_rdy      = reset ? '0   : req_rdy_c;
   assign bus.resp_val     = reset ? '0   : resp_val_c;
   assign bus.mul_req_val  = reset ? 1'b0 : mul_req_val_c;
   assign bus.mul_resp_rdy = reset ? 1'b0 : mul_resp_rdy_c;
   assign bus.mul_req_msg  = reset ? '0   : req_msg_lane[sel];
   assign bus.resp_msg     = reset ? '0   : {nreqs{bus.mul_resp_msg}};

endmodule

// File: tb/tb_imul_shared_arbiter.sv
// Bench for imul_shared_arbiter: 4-lane instance with a stub multiplier, plus a 3-lane wrap check.
module tb_imul_shared_arbiter;
   import imul_arb_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imul_shared_arbiter_if #(.nreqs(4)) if4 ();
   imul_shared_arbiter_if #(.nreqs(3)) if3 ();

   imul_shared_arbiter #(.nreqs(4)) dut  (.clk(clk), .reset(reset), .bus(if4));
   imul_shared_arbiter #(.nreqs(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

   int checks = 0;
   int errors = 0;
   int exp_ptr = 0;

   // Stub multiplier: accepts when idle, answers after stub_lat cycles.
   logic        stub_en    = 1'b1;
   int          stub_lat   = 2;
   logic        force_resp = 1'b0;
   logic        stub_busy, stub_rv;
   int          stub_cnt;
   logic [31:0] stub_prod;

   assign if4.mul_req_rdy  = stub_en && !stub_busy;
   assign if4.mul_resp_val = stub_rv | force_resp;
   assign if4.mul_resp_msg = force_resp ? 32'hDEAD_BEEF : stub_prod;

   always @(posedge clk) begin
      if (reset) begin
         stub_busy <= 1'b0;
         stub_rv   <= 1'b0;
         stub_cnt  <= 0;
         stub_prod <= '0;
      end else if (if4.mul_req_val && if4.mul_req_rdy) begin
         stub_busy <= 1'b1;
         stub_cnt  <= stub_lat;
         stub_prod <= if4.mul_req_msg[63:32] * if4.mul_req_msg[31:0];
      end else if (stub_busy && !stub_rv) begin
         if (stub_cnt <= 1) stub_rv <= 1'b1;
         else               stub_cnt <= stub_cnt - 1;
      end else if (stub_rv && if4.mul_resp_rdy) begin
         stub_rv   <= 1'b0;
         stub_busy <= 1'b0;
      end
   end

   function automatic int rr_pick(input logic [7:0] val, input int ptr, input int n);
      for (int k = 0; k < n; k++) begin
         if (val[(ptr + k) % n]) return (ptr + k) % n;
      end
      return -1;
   endfunction

   function automatic logic [31:0] prod(input logic [63:0] m);
      logic [31:0] a, b;
      a = m[63:32];
      b = m[31:0];
      return a * b;
   endfunction

   task automatic set_msg4(input int lane, input logic [63:0] m);
      if4.req_msg[lane*64 +: 64] = m;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      exp_ptr = 0;
   endtask

   // Waits (bounded) for one response handshake on the 4-lane DUT.
   task automatic drain(output int lane, output logic [31:0] m, output bit ok);
      lane = -1; m = '0; ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (|(if4.resp_val & if4.resp_rdy)) begin
            for (int i = 0; i < 4; i++) if (if4.resp_val[i]) lane = i;
            m  = if4.resp_msg[lane*32 +: 32];
            ok = 1'b1;
         end
         @(negedge clk);
         if (ok) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; force_resp = 1'b1; stub_en = 1'b1;
      if4.req_val = '1; if4.resp_rdy = '1;
      for (int i = 0; i < 4; i++) set_msg4(i, {$urandom, $urandom});
      #1;
      checks++; if (if4.req_rdy !== '0) begin errors++; $display("FAIL reset_req_rdy got %h want 0", if4.req_rdy); end
      checks++; if (if4.resp_val !== '0) begin errors++; $display("FAIL reset_resp_val got %h want 0", if4.resp_val); end
      checks++; if (if4.mul_req_val !== 1'b0) begin errors++; $display("FAIL reset_mul_req_val got %b want 0", if4.mul_req_val); end
      checks++; if (if4.mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_mul_resp_rdy got %b want 0", if4.mul_resp_rdy); end
      checks++; if (if4.mul_req_msg !== '0) begin errors++; $display("FAIL reset_mul_req_msg got %h want 0", if4.mul_req_msg); end
      checks++; if (if4.resp_msg !== '0) begin errors++; $display("FAIL reset_resp_msg got %h want 0", if4.resp_msg); end
      @(negedge clk);
      force_resp = 1'b0; if4.req_val = '0;
      reset = 1'b0; exp_ptr = 0;
      $display("reset: outputs checked while reset high");
   endtask

   task automatic test_unexpected_resp();
      @(negedge clk);
      force_resp = 1'b1;
      #1;
      checks++; if (if4.mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL unexp_mul_resp_rdy got %b want 0", if4.mul_resp_rdy); end
      checks++; if (if4.resp_val !== '0) begin errors++; $display("FAIL unexp_resp_val got %h want 0", if4.resp_val); end
      @(negedge clk);
      force_resp = 1'b0;
      $display("unexpected response in IDLE ignored");
   endtask

   task automatic test_single();
      bit seen = 1'b0;
      @(negedge clk);
      stub_lat = 2; if4.resp_rdy = '1;
      set_msg4(2, {32'd3, 32'd5});
      if4.req_val = 4'b0100;
      #1;
      checks++; if (if4.req_rdy !== 4'b0100 || if4.mul_req_val !== 1'b1) begin errors++; $display("FAIL single_fire got rdy=%b val=%b want rdy=0100 val=1", if4.req_rdy, if4.mul_req_val); end
      checks++; if (if4.mul_req_msg !== {32'd3, 32'd5}) begin errors++; $display("FAIL single_msg got %h want %h", if4.mul_req_msg, {32'd3, 32'd5}); end
      @(negedge clk);
      if4.req_val = '0;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (if4.resp_val !== '0) begin
            seen = 1'b1;
            checks++; if (if4.resp_val !== 4'b0100) begin errors++; $display("FAIL single_resp_lane got %b want 0100", if4.resp_val); end
            checks++; if (if4.resp_msg[95:64] !== 32'd15) begin errors++; $display("FAIL single_product got %0d want 15", if4.resp_msg[95:64]); end
            checks++; if (if4.mul_resp_rdy !== 1'b1) begin errors++; $display("FAIL single_mul_resp_rdy got %b want 1", if4.mul_resp_rdy); end
         end
         @(negedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL single_timeout got no response want one"); end
      exp_ptr = 3;
      $display("txn lane 2: 3 x 5");
   endtask

   task automatic test_ptr_after_single();
      int lane; logic [31:0] m; bit ok;
      logic [3:0] exp_rdy;
      for (int i = 0; i < 4; i++) set_msg4(i, {32'd2, 32'(i + 1)});
      if4.req_val = 4'hF;
      exp_rdy = '0; exp_rdy[rr_pick(8'h0F, exp_ptr, 4)] = 1'b1;
      #1;
      checks++; if (if4.req_rdy !== exp_rdy) begin errors++; $display("FAIL ptr_after_single got %b want %b", if4.req_rdy, exp_rdy); end
      @(negedge clk);
      if4.req_val = '0;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 3 || m !== 32'd8) begin errors++; $display("FAIL ptr_after_single_resp got lane=%0d prod=%0d want lane=3 prod=8", lane, m); end
      exp_ptr = 0;
      $display("txn lane 3: 2 x 4");
   endtask

   task automatic test_round_robin();
      logic [63:0] msgs [4];
      int order [5] = '{0, 1, 2, 3, 0};
      int ngrant = 0, nresp = 0, owner = 0;
      logic [3:0] exp_vec;
      pulse_reset();
      msgs[0] = {32'd7, 32'd6};
      msgs[1] = {32'hFFFF_FFFF, 32'd2};
      msgs[2] = {32'd0, 32'd9};
      msgs[3] = {32'd1, 32'd1};
      for (int i = 0; i < 4; i++) set_msg4(i, msgs[i]);
      stub_lat = 2; if4.resp_rdy = '1; if4.req_val = 4'hF;
      for (int c = 0; c < 200 && nresp < 5; c++) begin
         #1;
         if (|(if4.req_val & if4.req_rdy)) begin
            exp_vec = '0; exp_vec[order[ngrant]] = 1'b1;
            checks++; if (if4.req_rdy !== exp_vec) begin errors++; $display("FAIL rr_grant%0d got %b want %b", ngrant, if4.req_rdy, exp_vec); end
            checks++; if (if4.mul_req_msg !== msgs[order[ngrant]]) begin errors++; $display("FAIL rr_msg%0d got %h want %h", ngrant, if4.mul_req_msg, msgs[order[ngrant]]); end
            owner = order[ngrant];
            ngrant++;
         end
         if (|(if4.resp_val & if4.resp_rdy)) begin
            exp_vec = '0; exp_vec[owner] = 1'b1;
            checks++; if (if4.resp_val !== exp_vec) begin errors++; $display("FAIL rr_resp_lane%0d got %b want %b", nresp, if4.resp_val, exp_vec); end
            checks++; if (if4.resp_msg[owner*32 +: 32] !== prod(msgs[owner])) begin errors++; $display("FAIL rr_product%0d got %h want %h", nresp, if4.resp_msg[owner*32 +: 32], prod(msgs[owner])); end
            $display("txn lane %0d: product %h", owner, prod(msgs[owner]));
            nresp++;
         end
         @(negedge clk);
      end
      if4.req_val = '0;
      checks++; if (nresp != 5) begin errors++; $display("FAIL rr_timeout got %0d responses want 5", nresp); end
      exp_ptr = 1;
   endtask

   task automatic test_hold();
      int lane; logic [31:0] m; bit ok;
      logic [63:0] msg0 = {32'd2, 32'd2};
      logic [63:0] msg1 = {32'd11, 32'd13};
      pulse_reset();
      stub_en = 1'b0; if4.resp_rdy = '1;
      set_msg4(1, msg1);
      if4.req_val = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin set_msg4(0, msg0); if4.req_val = 4'b0011; end
         #1;
         checks++; if (if4.mul_req_msg !== msg1 || if4.mul_req_val !== 1'b1) begin errors++; $display("FAIL hold_msg_c%0d got %h val=%b want %h val=1", c, if4.mul_req_msg, if4.mul_req_val, msg1); end
         checks++; if (if4.req_rdy !== 4'b0000) begin errors++; $display("FAIL hold_rdy_c%0d got %b want 0000", c, if4.req_rdy); end
         @(negedge clk);
      end
      stub_en = 1'b1;
      #1;
      checks++; if (if4.req_rdy !== 4'b0010 || if4.mul_req_msg !== msg1) begin errors++; $display("FAIL hold_release got rdy=%b msg=%h want rdy=0010 msg=%h", if4.req_rdy, if4.mul_req_msg, msg1); end
      @(negedge clk);
      if4.req_val = 4'b0001;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 1 || m !== 32'd143) begin errors++; $display("FAIL hold_resp got lane=%0d prod=%0d want lane=1 prod=143", lane, m); end
      $display("txn lane 1: 11 x 13");
      #1;
      checks++; if (if4.req_rdy !== 4'b0001) begin errors++; $display("FAIL hold_second got %b want 0001", if4.req_rdy); end
      @(negedge clk);
      if4.req_val = '0;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 0 || m !== 32'd4) begin errors++; $display("FAIL hold_second_resp got lane=%0d prod=%0d want lane=0 prod=4", lane, m); end
      $display("txn lane 0: 2 x 2");
      exp_ptr = 1;
   endtask

   task automatic test_backpressure();
      int lane; logic [31:0] m; bit ok;
      bit seen = 1'b0;
      @(negedge clk);
      stub_lat = 1; if4.resp_rdy = '1;
      set_msg4(3, {32'd5, 32'd5});
      if4.req_val = 4'b1000;
      #1;
      checks++; if (if4.req_rdy !== 4'b1000) begin errors++; $display("FAIL bp_fire got %b want 1000", if4.req_rdy); end
      @(negedge clk);
      if4.resp_rdy = 4'b0111;
      set_msg4(0, {32'd4, 32'd4});
      if4.req_val = 4'b0001;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1;
         if (if4.resp_val[3] === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL bp_timeout got no response want one"); end
      for (int c = 0; c < 4; c++) begin
         checks++; if (if4.resp_val !== 4'b1000 || if4.mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall_c%0d got resp_val=%b mul_resp_rdy=%b want 1000/0", c, if4.resp_val, if4.mul_resp_rdy); end
         checks++; if (if4.mul_req_val !== 1'b0 || if4.req_rdy !== 4'b0000) begin errors++; $display("FAIL bp_no_req_c%0d got mul_req_val=%b req_rdy=%b want 0/0000", c, if4.mul_req_val, if4.req_rdy); end
         @(negedge clk);
         #1;
      end
      if4.resp_rdy = '1;
      #1;
      checks++; if (if4.mul_resp_rdy !== 1'b1 || if4.resp_msg[127:96] !== 32'd25) begin errors++; $display("FAIL bp_release got rdy=%b prod=%0d want 1/25", if4.mul_resp_rdy, if4.resp_msg[127:96]); end
      checks++; if (if4.req_rdy !== 4'b0000 || if4.mul_req_val !== 1'b0) begin errors++; $display("FAIL bp_same_cycle got rdy=%b val=%b want 0000/0", if4.req_rdy, if4.mul_req_val); end
      $display("txn lane 3: 5 x 5");
      @(negedge clk);
      #1;
      checks++; if (if4.mul_req_val !== 1'b1 || if4.req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_next_idle got val=%b rdy=%b want 1/0001", if4.mul_req_val, if4.req_rdy); end
      @(negedge clk);
      if4.req_val = '0;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 0 || m !== 32'd16) begin errors++; $display("FAIL bp_after got lane=%0d prod=%0d want lane=0 prod=16", lane, m); end
      $display("txn lane 0: 4 x 4");
      exp_ptr = 1;
   endtask

   task automatic test_reset_busy();
      int lane; logic [31:0] m; bit ok;
      logic [63:0] msg0 = {32'd8, 32'd9};
      @(negedge clk);
      set_msg4(3, {32'd6, 32'd7}); set_msg4(0, msg0);
      if4.resp_rdy = '0; if4.req_val = 4'b1000;
      #1;
      checks++; if (if4.req_rdy !== 4'b1000) begin errors++; $display("FAIL rb_fire got %b want 1000", if4.req_rdy); end
      @(negedge clk);
      if4.req_val = 4'b1001;
      #1;
      checks++; if (if4.req_rdy !== 4'b0000 || if4.mul_req_val !== 1'b0) begin errors++; $display("FAIL rb_busy got rdy=%b val=%b want 0000/0", if4.req_rdy, if4.mul_req_val); end
      @(negedge clk);
      reset = 1'b1; if4.resp_rdy = '1;
      #1;
      checks++; if (if4.req_rdy !== '0 || if4.resp_val !== '0 || if4.mul_req_val !== 1'b0) begin errors++; $display("FAIL rb_reset_hs got rdy=%b rv=%b mrv=%b want all 0", if4.req_rdy, if4.resp_val, if4.mul_req_val); end
      checks++; if (if4.mul_resp_rdy !== 1'b0 || if4.mul_req_msg !== '0 || if4.resp_msg !== '0) begin errors++; $display("FAIL rb_reset_data got mrr=%b msg=%h resp=%h want all 0", if4.mul_resp_rdy, if4.mul_req_msg, if4.resp_msg); end
      @(negedge clk);
      reset = 1'b0; exp_ptr = 0;
      #1;
      checks++; if (if4.req_rdy !== 4'b0001 || if4.mul_req_msg !== msg0) begin errors++; $display("FAIL rb_after got rdy=%b msg=%h want 0001/%h", if4.req_rdy, if4.mul_req_msg, msg0); end
      @(negedge clk);
      if4.req_val = 4'b1000;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 0 || m !== 32'd72) begin errors++; $display("FAIL rb_resp0 got lane=%0d prod=%0d want lane=0 prod=72", lane, m); end
      $display("txn lane 0: 8 x 9");
      @(negedge clk);
      if4.req_val = '0;
      drain(lane, m, ok);
      checks++; if (!ok || lane != 3 || m !== 32'd42) begin errors++; $display("FAIL rb_resp3 got lane=%0d prod=%0d want lane=3 prod=42", lane, m); end
      $display("txn lane 3: 6 x 7");
      exp_ptr = 0;
   endtask

   task automatic test_wrap3();
      @(negedge clk);
      if3.req_msg[128 +: 64] = {32'd10, 32'd3};
      if3.req_val = 3'b100; if3.mul_req_rdy = 1'b1; if3.resp_rdy = 3'b111;
      #1;
      checks++; if (if3.req_rdy !== 3'b100 || if3.mul_req_msg !== {32'd10, 32'd3}) begin errors++; $display("FAIL wrap_fire got rdy=%b msg=%h want 100", if3.req_rdy, if3.mul_req_msg); end
      @(negedge clk);
      if3.req_val = '0; if3.mul_req_rdy = 1'b0; if3.mul_resp_val = 1'b1; if3.mul_resp_msg = 32'd30;
      #1;
      checks++; if (if3.resp_val !== 3'b100 || if3.resp_msg[95:64] !== 32'd30) begin errors++; $display("FAIL wrap_resp got rv=%b prod=%0d want 100/30", if3.resp_val, if3.resp_msg[95:64]); end
      $display("txn n3 lane 2: 10 x 3");
      @(negedge clk);
      if3.mul_resp_val = 1'b0;
      if3.req_msg[0 +: 64] = {32'd1, 32'd2};
      if3.req_val = 3'b101; if3.mul_req_rdy = 1'b1;
      #1;
      checks++; if (if3.req_rdy !== 3'b001 || if3.mul_req_msg !== {32'd1, 32'd2}) begin errors++; $display("FAIL wrap_ptr got rdy=%b msg=%h want 001", if3.req_rdy, if3.mul_req_msg); end
      @(negedge clk);
      if3.req_val = '0; if3.mul_req_rdy = 1'b0; if3.mul_resp_val = 1'b1; if3.mul_resp_msg = 32'd2;
      #1;
      checks++; if (if3.resp_val !== 3'b001) begin errors++; $display("FAIL wrap_resp0 got %b want 001", if3.resp_val); end
      $display("txn n3 lane 0: 1 x 2");
      @(negedge clk);
      if3.mul_resp_val = 1'b0;
   endtask

   task automatic test_random();
      logic [63:0] q [4][$];
      bit m_free = 1'b1, m_issued = 1'b0, fire_now, resp_now;
      int m_owner = 0, done = 0;
      logic [63:0] m_msg = '0;
      logic [3:0] exp_vec;
      pulse_reset();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++)
            q[i].push_back({$urandom, 16'h0, 16'($urandom)});
      for (int c = 0; c < 4000 && done < 16; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!if4.req_val[i] && q[i].size() > 0 && $urandom_range(0, 3) == 0) begin
               set_msg4(i, q[i][0]);
               if4.req_val[i] = 1'b1;
            end
         end
         if4.resp_rdy = 4'($urandom);
         stub_en  = ($urandom_range(0, 3) != 0);
         stub_lat = $urandom_range(1, 3);
         fire_now = 1'b0; resp_now = 1'b0;
         #1;
         if (m_free && |if4.req_val) begin
            m_owner  = rr_pick({4'b0, if4.req_val}, exp_ptr, 4);
            m_msg    = q[m_owner][0];
            m_free   = 1'b0;
            m_issued = 1'b0;
         end
         if (!m_free && !m_issued) begin
            exp_vec = '0; exp_vec[m_owner] = if4.mul_req_rdy;
            checks++; if (if4.mul_req_val !== 1'b1 || if4.mul_req_msg !== m_msg) begin errors++; $display("FAIL rnd_req got val=%b msg=%h want 1/%h", if4.mul_req_val, if4.mul_req_msg, m_msg); end
            checks++; if (if4.req_rdy !== exp_vec) begin errors++; $display("FAIL rnd_req_rdy got %b want %b", if4.req_rdy, exp_vec); end
            fire_now = if4.mul_req_rdy;
         end else if (!m_free) begin
            exp_vec = '0; exp_vec[m_owner] = if4.mul_resp_val;
            checks++; if (if4.mul_req_val !== 1'b0 || if4.req_rdy !== 4'b0000) begin errors++; $display("FAIL rnd_busy_req got val=%b rdy=%b want 0/0000", if4.mul_req_val, if4.req_rdy); end
            checks++; if (if4.resp_val !== exp_vec || if4.mul_resp_rdy !== if4.resp_rdy[m_owner]) begin errors++; $display("FAIL rnd_resp_route got rv=%b mrr=%b want %b/%b", if4.resp_val, if4.mul_resp_rdy, exp_vec, if4.resp_rdy[m_owner]); end
            if (if4.mul_resp_val && if4.resp_rdy[m_owner]) begin
               checks++; if (if4.resp_msg !== {4{prod(m_msg)}}) begin errors++; $display("FAIL rnd_product got %h want %h", if4.resp_msg, {4{prod(m_msg)}}); end
               resp_now = 1'b1;
            end
         end else begin
            checks++; if (if4.mul_req_val !== 1'b0 || if4.resp_val !== '0 || if4.mul_resp_rdy !== 1'b0) begin errors++; $display("FAIL rnd_idle got mrv=%b rv=%b mrr=%b want 0", if4.mul_req_val, if4.resp_val, if4.mul_resp_rdy); end
         end
         @(negedge clk);
         if (fire_now) begin
            void'(q[m_owner].pop_front());
            if4.req_val[m_owner] = 1'b0;
            m_issued = 1'b1;
         end
         if (resp_now) begin
            $display("txn lane %0d: %h x %h = %h", m_owner, m_msg[63:32], m_msg[31:0], prod(m_msg));
            m_free  = 1'b1;
            exp_ptr = (m_owner + 1) % 4;
            done++;
         end
      end
      if4.req_val = '0; if4.resp_rdy = '1; stub_en = 1'b1;
      checks++; if (done != 16) begin errors++; $display("FAIL rnd_timeout got %0d responses want 16", done); end
   endtask

   initial begin
      if4.req_val = '0; if4.resp_rdy = '1; if4.req_msg = '0;
      if3.req_val = '0; if3.resp_rdy = '0; if3.req_msg = '0;
      if3.mul_req_rdy = 1'b0; if3.mul_resp_val = 1'b0; if3.mul_resp_msg = '0;
      test_reset();
      test_unexpected_resp();
      test_single();
      test_ptr_after_single();
      test_round_robin();
      test_hold();
      test_backpressure();
      test_reset_busy();
      test_wrap3();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
